sw_debounce: RTL
================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 4: number of switch channels.
REQ-002 Parameter CNT_MAX, default 8: consecutive cycles a synchronized input must differ from the debounced value before it is accepted; legal range 1..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 4: per-channel counter width.
REQ-004 clk  input  1  single system clock; all flops rise-edge triggered.
REQ-005 rst_n  input  1  asynchronous, active-low reset; assertion acts immediately, release is sampled on clk.
REQ-006 sw_in  input  WIDTH  raw switch levels, asynchronous to clk, may bounce.
REQ-007 sw_out  output  WIDTH  debounced switch levels, the feed for the LED passthrough stage.
REQ-008 sw_rise  output  WIDTH  one-cycle pulse per channel on a 0->1 change of sw_out.
REQ-009 sw_fall  output  WIDTH  one-cycle pulse per channel on a 1->0 change of sw_out.
REQ-010 sw_changed  output  1  OR-reduction of (sw_rise | sw_fall), registered-equivalent timing.
REQ-011 busy  output  1  high while any channel counter is non-zero.

Function
REQ-012 Each sw_in bit passes through a 2-flop synchronizer; s[i] is the second-stage output, and no logic other than the first stage samples sw_in.
REQ-013 Per channel: if s[i] == sw_out[i] on an edge, the counter is cleared to 0.
REQ-014 Per channel: if s[i] != sw_out[i] and counter < CNT_MAX-1, the counter increments by 1.
REQ-015 Per channel: if s[i] != sw_out[i] and counter == CNT_MAX-1, sw_out[i] takes s[i], the counter clears, and the matching rise/fall bit is set, all on that edge.
REQ-016 Latency: sw_in changing and then held stable before edge k (first sampling edge) produces a new sw_out at edge k+CNT_MAX+1; CNT_MAX=8 gives 9 edges.
REQ-017 sw_rise/sw_fall are registered, high for exactly one cycle, aligned with the first cycle sw_out shows the new value; they are never both high for one bit.
REQ-018 Glitch rejection: if s[i] returns to sw_out[i] before the threshold, the counter clears, and sw_out and the pulses do not change.
REQ-019 The counter never wraps; it is bounded by CNT_MAX-1 under all input patterns.
REQ-020 Channels are independent; simultaneous changes on several bits produce pulses on the same cycle, with a single-cycle sw_changed.
REQ-021 busy is combinational from the counters: OR over channels of (counter != 0).
REQ-022 CNT_MAX=1: a mismatch on s is accepted on the very next edge (latency k+2).

Reset
REQ-023 While rst_n=0: synchronizer flops, counters, sw_out, sw_rise, sw_fall, sw_changed, and busy are all 0.
REQ-024 Reset mid-count discards the partial count; no pulse is generated by the reset itself.
REQ-025 After release, inputs held at 1 are treated as a change from 0: sw_out rises at edge k+CNT_MAX+1 counted from the first post-release edge k, with sw_rise asserted.

Verification (CNT_MAX=8, WIDTH=4)
REQ-026 rst_n low for 3 cycles, then high, with sw_in=0000 for 20 cycles -> every output stays 0 and busy stays 0.
REQ-027 sw_in 0000->0001, held -> sw_out=0001 at edge k+9, sw_rise=0001 and sw_changed=1 for exactly one cycle, busy high for edges k+2..k+8.
REQ-028 sw_in[1] high for 5 cycles, then low -> sw_out unchanged, no pulses, busy returns to 0 two edges after the input falls.
REQ-029 sw_in counts 0..15, stepping every 10 cycles -> sw_out follows each value 9 edges later, and rise/fall pulses match the per-bit transitions of each step.
REQ-030 sw_out=0001, then sw_in->1000 in a single step -> sw_rise=1000 and sw_fall=0001 on the same cycle, sw_changed high for that one cycle only.
REQ-031 sw_in=1111, rst_n pulsed low at count 5 -> all outputs 0 immediately; after release, sw_out=1111 with sw_rise=1111 at edge k+9.

Source files
------------

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce -- multi-channel switch debouncer
//
// Each raw switch bit is brought into the clk domain through a 2-flop
// synchronizer. A per-channel counter then measures how long the
// synchronized level has disagreed with the debounced output. The new level
// is accepted once it has disagreed on CNT_MAX consecutive edges.
//
// Ports (top):
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   sw_in      [WIDTH] raw switch levels (asynchronous, bouncy)
//   sw_out     [WIDTH] debounced levels
//   sw_rise    [WIDTH] one-cycle pulse on a 0->1 change of sw_out
//   sw_fall    [WIDTH] one-cycle pulse on a 1->0 change of sw_out
//   sw_changed one-cycle pulse when any rise/fall pulse is high
//   busy       any channel counter non-zero (combinational)
// ---------------------------------------------------------------------------

// One debounce channel: synchronizer, stability counter, output and edge flops.
module sw_debounce_lane #(
    parameter int CNT_MAX = 8,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic out_o,
    output logic rise_o,
    output logic fall_o,
    output logic ev_o,     // next-state of rise|fall, for the shared change flop
    output logic busy_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Only sync1_q ever looks at the raw input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
        end
    end

    // Any agreement clears the count, so a glitch shorter than the threshold
    // leaves no trace. The >= compare keeps the counter pinned below
    // CNT_MAX even if it were somehow disturbed.
    always_comb begin
        cnt_d  = '0;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync2_q != out_q) begin
            if (cnt_q >= CNT_LAST) begin
                out_d  = sync2_q;
                rise_d = sync2_q;
                fall_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign out_o  = out_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign ev_o   = rise_d | fall_d;
    assign busy_o = |cnt_q;
endmodule

module sw_debounce #(
    parameter int WIDTH   = 4,
    parameter int CNT_MAX = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed,
    output logic             busy
);
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] lane_busy;
    logic             changed_q, changed_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        sw_debounce_lane #(
            .CNT_MAX(CNT_MAX),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .sw_i  (sw_in[i]),
            .out_o (sw_out[i]),
            .rise_o(sw_rise[i]),
            .fall_o(sw_fall[i]),
            .ev_o  (ev[i]),
            .busy_o(lane_busy[i])
        );
    end

    // Registered from the lanes' next-state pulses so it lines up with
    // sw_rise/sw_fall rather than trailing them by a cycle.
    assign changed_d = |ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) changed_q <= 1'b0;
        else        changed_q <= changed_d;
    end

    assign sw_changed = changed_q;
    assign busy       = |lane_busy;
endmodule
